pipelined_mul_unit: RTL and testbench

- Parametrised multiply unit for the EX stage. It replaces the fixed single-cycle multiply path and its blocking stall_mul behaviour.
- Supports all four RV32M multiply ops (MUL, MULH, MULHSU, MULHU), a configurable pipeline depth, and a fully-pipelined or blocking issue mode.
- Responds to the global pipeline stall (dCache/load-use) and to flush from taken branches/exceptions, so results retire in order to EX/MEM.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_pipe_stage.sv | 31 +++
 rtl/pipelined_mul_unit.sv | 109 ++++++++++
 tb/tb_pipelined_mul_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the EX-stage multiply unit: op encoding, depth limit and
// operand-extension rules.
package mul_pkg;

  localparam int unsigned MUL_MAX_STAGES = 8;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_t;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic mulSignA(input mul_op_t op);
    return (op == MUL_HSS) || (op == MUL_HSU);
  endfunction

  // rs2 is treated as signed for MULH only.
  function automatic logic mulSignB(input mul_op_t op);
    return (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One multiply pipeline register: valid bit plus payload, held on stall,
// valid cleared on flush.
module mul_pipe_stage #(
  parameter type T = logic
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  input  logic flush,
  input  logic inValid,
  input  T     inData,
  output logic outValid,
  output T     outData
);

  // Flush only kills the valid bit; the payload is don't-care once invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (!stall) begin
      outValid <= inValid;
      if (inValid) begin
        outData <= inData;
      end
    end
  end

endmodule

// File: rtl/pipelined_mul_unit.sv
// RV32M multiply unit for EX: MUL/MULH/MULHSU/MULHU over a STAGES-deep pipe,
// honouring the global stall and branch/exception flush.
module pipelined_mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STAGES    = 3,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned PIPELINED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PW = 2 * XLEN + 2;

  // Sized from the module parameters, so it lives here rather than in the
  // package. data is {a_ext, b_ext} in stage 1 and the product afterwards;
  // both are PW bits wide.
  typedef struct packed {
    mul_op_t          op;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    data;
  } mul_stage_t;

  mul_stage_t        stageQ [STAGES];
  logic [STAGES-1:0] stageValid;
  mul_stage_t        issueData;
  mul_op_t           inOp;
  logic              accept;
  logic [XLEN:0]     aExt;
  logic [XLEN:0]     bExt;
  logic signed [PW-1:0] opA;
  logic signed [PW-1:0] opB;
  logic signed [PW-1:0] product;
  logic [PW-1:0]     lastData;
  logic              unusedTop;

  assign busy      = |stageValid;
  assign in_ready  = !reset && !stall && !flush && ((PIPELINED != 0) || !busy);
  assign accept    = in_valid && in_ready;
  assign inOp      = mul_op_t'(in_op);
  assign out_valid = stageValid[STAGES-1];
  assign out_tag   = stageQ[STAGES-1].tag;

  always_comb begin
    aExt      = {mulSignA(inOp) & in_a[XLEN-1], in_a};
    bExt      = {mulSignB(inOp) & in_b[XLEN-1], in_b};
    issueData = '{op: inOp, tag: in_tag, data: {aExt, bExt}};
  end

  // The PW-bit product of two sign-extended XLEN+1 operands is exact, so a
  // plain truncating multiply at PW width is sufficient.
  always_comb begin
    opA      = PW'($signed(stageQ[0].data[PW-1:XLEN+1]));
    opB      = PW'($signed(stageQ[0].data[XLEN:0]));
    product  = opA * opB;
    lastData = (STAGES == 1) ? product : stageQ[STAGES-1].data;
    if (stageQ[STAGES-1].op == MUL_LO) begin
      out_result = lastData[XLEN-1:0];
    end else begin
      out_result = lastData[2*XLEN-1:XLEN];
    end
  end

  assign unusedTop = ^lastData[PW-1:2*XLEN];

  for (genvar i = 0; i < STAGES; i++) begin : gStage
    mul_stage_t dIn;
    logic       vIn;

    if (i == 0) begin : gIssue
      assign vIn = accept;
      assign dIn = issueData;
    end else if (i == 1) begin : gProduct
      assign vIn = stageValid[0];
      assign dIn = '{op: stageQ[0].op, tag: stageQ[0].tag, data: product};
    end else begin : gCarry
      assign vIn = stageValid[i-1];
      assign dIn = stageQ[i-1];
    end

    mul_pipe_stage #(
      .T(mul_stage_t)
    ) uStage (
      .clock   (clock),
      .reset   (reset),
      .stall   (stall),
      .flush   (flush),
      .inValid (vIn),
      .inData  (dIn),
      .outValid(stageValid[i]),
      .outData (stageQ[i])
    );
  end

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Self-checking bench for pipelined_mul_unit: a pipelined and a blocking
// instance, scoreboarded results, and hand-written stall/flush/reset sequences.
module tb_pipelined_mul_unit;

  localparam int unsigned STAGES = 3;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic        inValid, inReady, outValid, busy;
  logic [1:0]  inOp;
  logic [31:0] inA, inB, outResult, expRes;
  logic [4:0]  inTag, outTag;
  logic        inValidB, inReadyB, outValidB, busyB;
  logic [1:0]  inOpB;
  logic [31:0] inAB, inBB, outResultB, expResB;
  logic [4:0]  inTagB, outTagB;

  typedef struct packed { logic [31:0] res; logic [4:0] tag; } sb_t;
  typedef struct packed {
    logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] tag; logic [31:0] exp;
  } vec_t;

  sb_t         sbA[$], sbB[$];
  sb_t         eA, eB;
  int          tests = 0, fails = 0;
  int unsigned cyc = 0, popsA = 0;
  int unsigned doneCycB[$];

  pipelined_mul_unit #(.XLEN(32), .STAGES(STAGES), .TAG_W(5), .PIPELINED(1)) dut (
    .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .in_op(inOp), .in_a(inA), .in_b(inB), .in_tag(inTag), .stall(stall),
    .flush(flush), .out_valid(outValid), .out_result(outResult),
    .out_tag(outTag), .busy(busy));

  pipelined_mul_unit #(.XLEN(32), .STAGES(STAGES), .TAG_W(5), .PIPELINED(0)) dutB (
    .clock(clock), .reset(reset), .in_valid(inValidB), .in_ready(inReadyB),
    .in_op(inOpB), .in_a(inAB), .in_b(inBB), .in_tag(inTagB), .stall(stall),
    .flush(flush), .out_valid(outValidB), .out_result(outResultB),
    .out_tag(outTagB), .busy(busyB));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference built from 64-bit integer arithmetic on the 32-bit operands.
  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      2'd1:    p = 64'(sa * sb);
      2'd2:    p = 64'(sa * ub);
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge reset) begin
    sbA.delete();
    sbB.delete();
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (outValid && !stall) begin
        if (sbA.size() == 0) chkb("A unexpected out_valid", outValid, 1'b0);
        else begin
          eA = sbA.pop_front();
          chk("A result", outResult, eA.res);
          chk("A tag", 32'(outTag), 32'(eA.tag));
          popsA++;
        end
      end
      if (flush) sbA.delete();
      else if (inValid && inReady) sbA.push_back('{res: expRes, tag: inTag});
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (outValidB && !stall) begin
        if (sbB.size() == 0) chkb("B unexpected out_valid", outValidB, 1'b0);
        else begin
          eB = sbB.pop_front();
          chk("B result", outResultB, eB.res);
          chk("B tag", 32'(outTagB), 32'(eB.tag));
          doneCycB.push_back(cyc);
        end
      end
      if (flush) sbB.delete();
      else if (inValidB && inReadyB) sbB.push_back('{res: expResB, tag: inTagB});
    end
  end

  // Presents one op on the pipelined DUT and returns #1 after the accepting edge.
  task automatic issueA(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input bit rndStall,
                        output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    inOp = op; inA = a; inB = b; inTag = tag; expRes = exp; inValid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      if (rndStall) stall = ($urandom_range(3) == 0);
      @(negedge clock);
      acc = inReady;
      @(posedge clock);
      #1;
      if (!acc) waited++;
    end
    if (rndStall) stall = 1'b0;
    if (!acc) chkb("A issue timeout", acc, 1'b1);
  endtask

  task automatic drainA();
    for (int n = 0; n < 40 && (sbA.size() != 0 || busy); n++) begin
      @(posedge clock);
      #1;
    end
    chk("A scoreboard drained", 32'(sbA.size()), 32'd0);
    chkb("A idle after drain", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vec[12];
    logic [31:0] edgeVals[4];
    logic [1:0]  bOp[3];
    logic [31:0] bA[3], bB[3], bExp[3];
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          w, wTot, nAcc;
    int unsigned p0;
    bit          acc, viol;

    vec[0]  = '{op: 2'd0, a: 32'h00000007, b: 32'hFFFFFFFD, tag: 5'd5,  exp: 32'hFFFFFFEB};
    vec[1]  = '{op: 2'd1, a: 32'h80000000, b: 32'h80000000, tag: 5'd1,  exp: 32'h40000000};
    vec[2]  = '{op: 2'd2, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, tag: 5'd2,  exp: 32'hFFFFFFFF};
    vec[3]  = '{op: 2'd3, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, tag: 5'd3,  exp: 32'hFFFFFFFE};
    vec[4]  = '{op: 2'd3, a: 32'h00000003, b: 32'h00000005, tag: 5'd4,  exp: 32'h00000000};
    vec[5]  = '{op: 2'd0, a: 32'h00000002, b: 32'h00000003, tag: 5'd6,  exp: 32'h00000006};
    vec[6]  = '{op: 2'd0, a: 32'h00010000, b: 32'h00010000, tag: 5'd7,  exp: 32'h00000000};
    vec[7]  = '{op: 2'd1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, tag: 5'd8,  exp: 32'h00000000};
    vec[8]  = '{op: 2'd1, a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, tag: 5'd9,  exp: 32'h3FFFFFFF};
    vec[9]  = '{op: 2'd2, a: 32'h80000000, b: 32'hFFFFFFFF, tag: 5'd10, exp: 32'h80000000};
    vec[10] = '{op: 2'd1, a: 32'h80000000, b: 32'h7FFFFFFF, tag: 5'd11, exp: 32'hC0000000};
    vec[11] = '{op: 2'd3, a: 32'h80000000, b: 32'h00000002, tag: 5'd12, exp: 32'h00000001};
    edgeVals = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000};
    bOp  = '{2'd0, 2'd3, 2'd1};
    bA   = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFE};
    bB   = '{32'd6, 32'd2, 32'd3};
    bExp = '{32'd30, 32'd1, 32'hFFFFFFFF};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    inValid = 1'b0; inOp = '0; inA = '0; inB = '0; inTag = '0; expRes = '0;
    inValidB = 1'b0; inOpB = '0; inAB = '0; inBB = '0; inTagB = '0; expResB = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chkb("reset out_valid", outValid, 1'b0);
    chk("reset out_result", outResult, 32'd0);
    chk("reset out_tag", 32'(outTag), 32'd0);
    chkb("reset busy", busy, 1'b0);
    chkb("reset in_ready", inReady, 1'b0);
    chkb("reset B in_ready", inReadyB, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chkb("post-reset in_ready", inReady, 1'b1);

    // Single-op latency: valid after edge k+2
    issueA(vec[0].op, vec[0].a, vec[0].b, vec[0].tag, vec[0].exp, 1'b0, w);
    inValid = 1'b0;
    chkb("latency k+0 out_valid", outValid, 1'b0);
    @(posedge clock); #1;
    chkb("latency k+1 out_valid", outValid, 1'b0);
    @(posedge clock); #1;
    chkb("latency k+2 out_valid", outValid, 1'b1);
    chk("latency result", outResult, 32'hFFFFFFEB);
    chk("latency tag", 32'(outTag), 32'd5);
    @(posedge clock); #1;
    chkb("latency k+3 out_valid", outValid, 1'b0);

    // Table ops issued back-to-back: one result per cycle, in order
    p0 = popsA;
    wTot = 0;
    for (int i = 1; i < 12; i++) begin
      issueA(vec[i].op, vec[i].a, vec[i].b, vec[i].tag, vec[i].exp, 1'b0, w);
      wTot += w;
    end
    inValid = 1'b0;
    chk("back-to-back accept waits", 32'(wTot), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #7;
    chk("back-to-back results by last+2", popsA - p0, 32'd11);
    @(posedge clock); #1;
    chkb("back-to-back then idle", outValid, 1'b0);

    // Stall for 4 cycles with two ops in flight, first one at the output
    issueA(2'd0, 32'h00001234, 32'h00000010, 5'd13, 32'h00012340, 1'b0, w);
    issueA(2'd3, 32'hFFFFFFFF, 32'h00000010, 5'd14, 32'h0000000F, 1'b0, w);
    inValid = 1'b0;
    @(posedge clock); #1;
    chkb("stall pre out_valid", outValid, 1'b1);
    stall = 1'b1;
    inValid = 1'b1; inTag = 5'd31; expRes = 32'hDEADBEEF;
    for (int n = 0; n < 4; n++) begin
      @(posedge clock); #1;
      chkb("stall hold out_valid", outValid, 1'b1);
      chk("stall hold result", outResult, 32'h00012340);
      chk("stall hold tag", 32'(outTag), 32'd13);
      chkb("stall in_ready", inReady, 1'b0);
    end
    stall = 1'b0;
    inValid = 1'b0;
    @(posedge clock); #1;
    chkb("stall release second valid", outValid, 1'b1);
    chk("stall release second tag", 32'(outTag), 32'd14);
    @(posedge clock); #1;
    chkb("stall release idle", outValid, 1'b0);
    chkb("stall release busy", busy, 1'b0);

    // Flush the cycle after two accepts, with in_valid still high
    issueA(2'd0, 32'h11, 32'h11, 5'd15, 32'h121, 1'b0, w);
    issueA(2'd1, 32'h7, 32'h9, 5'd16, 32'h0, 1'b0, w);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    inValid = 1'b0;
    chkb("flush out_valid", outValid, 1'b0);
    chkb("flush busy", busy, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
    end
    chkb("flush stays idle", busy, 1'b0);
    issueA(2'd3, 32'd3, 32'd5, 5'd9, 32'd0, 1'b0, w);
    inValid = 1'b0;
    drainA();

    // Random ops with random stall, checked against the integer reference
    for (int i = 0; i < 24; i++) begin
      ra  = ($urandom_range(3) == 0) ? edgeVals[$urandom_range(3)] : $urandom();
      rb  = ($urandom_range(3) == 0) ? edgeVals[$urandom_range(3)] : $urandom();
      rop = 2'($urandom_range(3));
      issueA(rop, ra, rb, 5'(i), refMul(rop, ra, rb), 1'b1, w);
    end
    inValid = 1'b0;
    drainA();

    // Blocking instance: in_valid held across three ops
    nAcc = 0;
    viol = 1'b0;
    inOpB = bOp[0]; inAB = bA[0]; inBB = bB[0]; inTagB = 5'd1; expResB = bExp[0];
    inValidB = 1'b1;
    for (int n = 0; n < 40 && nAcc < 3; n++) begin
      @(negedge clock);
      if (inReadyB && busyB) viol = 1'b1;
      acc = inReadyB;
      @(posedge clock); #1;
      if (acc) begin
        nAcc++;
        if (nAcc < 3) begin
          inOpB = bOp[nAcc]; inAB = bA[nAcc]; inBB = bB[nAcc];
          inTagB = 5'(nAcc + 1); expResB = bExp[nAcc];
        end else inValidB = 1'b0;
      end
    end
    inValidB = 1'b0;
    for (int n = 0; n < 20 && (sbB.size() != 0 || busyB); n++) begin
      @(posedge clock); #1;
    end
    chk("B accepts", 32'(nAcc), 32'd3);
    chkb("B in_ready while busy", viol, 1'b0);
    chk("B completions", 32'(doneCycB.size()), 32'd3);
    if (doneCycB.size() == 3) begin
      chk("B spacing 1-2", doneCycB[1] - doneCycB[0], STAGES + 1);
      chk("B spacing 2-3", doneCycB[2] - doneCycB[1], STAGES + 1);
    end

    // Asynchronous reset between edges with a result at the output
    issueA(2'd0, 32'h100, 32'h100, 5'd20, 32'h10000, 1'b0, w);
    issueA(2'd0, 32'd5, 32'd5, 5'd21, 32'd25, 1'b0, w);
    inValid = 1'b0;
    @(posedge clock); #1;
    chkb("pre-reset out_valid", outValid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chkb("async reset out_valid", outValid, 1'b0);
    chk("async reset out_result", outResult, 32'd0);
    chk("async reset out_tag", 32'(outTag), 32'd0);
    chkb("async reset busy", busy, 1'b0);
    chkb("async reset in_ready", inReady, 1'b0);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    chkb("post-reset no out_valid", outValid, 1'b0);
    issueA(2'd0, 32'd2, 32'd3, 5'd3, 32'd6, 1'b0, w);
    inValid = 1'b0;
    drainA();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
